// File: rtl/gram_sched_ctrl.sv
// Load/compute sequencer for the Gram product B = A'A on a two-MAC datapath.
// Walks the coefficient load, then feeds upper-triangle pairs two at a time.
//
// state     | meaning
// S_IDLE    | waiting for cf_load after reset
// S_LOAD    | one-hot ld_sel walks over all ROWS*COLS coefficients
// S_COMPUTE | group g, step k: both MACs accumulate a_ki*a_kj
// S_DRAIN   | last group's results are strobed out
// S_DONE    | output_rdy held until the next cf_load
module gram_sched_ctrl #(
    parameter int ROWS  = 3,
    parameter int COLS  = 4,
    parameter int SEL_W = 4,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cf_load,
    output logic [ROWS*COLS-1:0]   ld_sel,
    output logic                   busy,
    output logic                   output_rdy,
    output logic [SEL_W-1:0]       mac1a_sel,
    output logic [SEL_W-1:0]       mac1b_sel,
    output logic [SEL_W-1:0]       mac2a_sel,
    output logic [SEL_W-1:0]       mac2b_sel,
    output logic                   mac1_en,
    output logic                   mac2_en,
    output logic                   mac1_clr,
    output logic                   mac2_clr,
    output logic                   mac1_out_vld,
    output logic                   mac2_out_vld,
    output logic [IDX_W-1:0]       mac1_out_idx,
    output logic [IDX_W-1:0]       mac2_out_idx
);

    localparam int L    = ROWS * COLS;
    localparam int P    = COLS * (COLS + 1) / 2;
    localparam int G    = (P + 1) / 2;
    localparam int LD_W = $clog2(L + 1);
    localparam int K_W  = $clog2(ROWS + 1);
    localparam int G_W  = $clog2(G + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;

    state_t            state;
    logic [LD_W-1:0]   ld_cnt;
    logic [K_W-1:0]    k_cnt;
    logic [G_W-1:0]    g_cnt;

    function automatic int pair_i(input int p);
        int c;
        int r;
        c = 0;
        r = 0;
        for (int i = 0; i < COLS; i++)
            for (int j = i; j < COLS; j++) begin
                if (c == p) r = i;
                c++;
            end
        return r;
    endfunction

    function automatic int pair_j(input int p);
        int c;
        int r;
        c = 0;
        r = 0;
        for (int i = 0; i < COLS; i++)
            for (int j = i; j < COLS; j++) begin
                if (c == p) r = j;
                c++;
            end
        return r;
    endfunction

    int                g_i, k_i, ng, nk, p1, p2;
    logic              nxt_cmp, n1_en, n2_en, n_clr;
    logic [SEL_W-1:0]  n1a, n1b, n2a, n2b;

    // Operand selects for the cycle that follows this edge.
    always_comb begin
        g_i     = int'(g_cnt);
        k_i     = int'(k_cnt);
        ng      = 0;
        nk      = 0;
        nxt_cmp = 1'b0;
        if (state == S_LOAD && int'(ld_cnt) == L - 1) begin
            nxt_cmp = 1'b1;
        end else if (state == S_COMPUTE) begin
            if (k_i == ROWS - 1) begin
                ng      = g_i + 1;
                nxt_cmp = (g_i != G - 1);
            end else begin
                ng      = g_i;
                nk      = k_i + 1;
                nxt_cmp = 1'b1;
            end
        end
        p1    = 2 * ng;
        p2    = 2 * ng + 1;
        n1_en = nxt_cmp && (p1 < P);
        n2_en = nxt_cmp && (p2 < P);
        n_clr = (nk == 0);
        n1a   = n1_en ? SEL_W'(pair_i(p1) * ROWS + nk) : '0;
        n1b   = n1_en ? SEL_W'(pair_j(p1) * ROWS + nk) : '0;
        n2a   = n2_en ? SEL_W'(pair_i(p2) * ROWS + nk) : '0;
        n2b   = n2_en ? SEL_W'(pair_j(p2) * ROWS + nk) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            ld_cnt       <= '0;
            k_cnt        <= '0;
            g_cnt        <= '0;
            ld_sel       <= '0;
            busy         <= 1'b0;
            output_rdy   <= 1'b0;
            mac1a_sel    <= '0;
            mac1b_sel    <= '0;
            mac2a_sel    <= '0;
            mac2b_sel    <= '0;
            mac1_en      <= 1'b0;
            mac2_en      <= 1'b0;
            mac1_clr     <= 1'b0;
            mac2_clr     <= 1'b0;
            mac1_out_vld <= 1'b0;
            mac2_out_vld <= 1'b0;
            mac1_out_idx <= '0;
            mac2_out_idx <= '0;
        end else if (cf_load) begin
            state        <= S_LOAD;
            ld_cnt       <= '0;
            k_cnt        <= '0;
            g_cnt        <= '0;
            ld_sel       <= L'(1);
            busy         <= 1'b1;
            output_rdy   <= 1'b0;
            mac1a_sel    <= '0;
            mac1b_sel    <= '0;
            mac2a_sel    <= '0;
            mac2b_sel    <= '0;
            mac1_en      <= 1'b0;
            mac2_en      <= 1'b0;
            mac1_clr     <= 1'b0;
            mac2_clr     <= 1'b0;
            mac1_out_vld <= 1'b0;
            mac2_out_vld <= 1'b0;
            mac1_out_idx <= '0;
            mac2_out_idx <= '0;
        end else begin
            mac1a_sel    <= n1a;
            mac1b_sel    <= n1b;
            mac2a_sel    <= n2a;
            mac2b_sel    <= n2b;
            mac1_en      <= n1_en;
            mac2_en      <= n2_en;
            mac1_clr     <= n1_en && n_clr;
            mac2_clr     <= n2_en && n_clr;
            mac1_out_vld <= 1'b0;
            mac2_out_vld <= 1'b0;
            mac1_out_idx <= '0;
            mac2_out_idx <= '0;
            case (state)
                S_LOAD: begin
                    ld_sel <= ld_sel << 1;
                    ld_cnt <= ld_cnt + 1'b1;
                    if (nxt_cmp) begin
                        state <= S_COMPUTE;
                        g_cnt <= '0;
                        k_cnt <= '0;
                    end
                end
                S_COMPUTE: begin
                    // Last step of a group: its results are complete next cycle.
                    if (k_i == ROWS - 1) begin
                        mac1_out_vld <= 1'b1;
                        mac1_out_idx <= IDX_W'(2 * g_i);
                        if (2 * g_i + 1 < P) begin
                            mac2_out_vld <= 1'b1;
                            mac2_out_idx <= IDX_W'(2 * g_i + 1);
                        end
                    end
                    g_cnt <= G_W'(ng);
                    k_cnt <= K_W'(nk);
                    if (!nxt_cmp) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    state      <= S_DONE;
                    busy       <= 1'b0;
                    output_rdy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gram_sched_ctrl.sv
// Bench for gram_sched_ctrl: three sizes (3x4, 2x2, 1x3) run side by side and
// every output is compared each cycle against a cycle-offset reference model.
module tb_gram_sched_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, cf_d, cf_s, cf_r;

    logic [11:0] d_ld_sel;
    logic        d_busy, d_rdy, d_en1, d_en2, d_clr1, d_clr2, d_v1, d_v2;
    logic [3:0]  d_m1a, d_m1b, d_m2a, d_m2b, d_i1, d_i2;

    logic [3:0]  s_ld_sel;
    logic        s_busy, s_rdy, s_en1, s_en2, s_clr1, s_clr2, s_v1, s_v2;
    logic [1:0]  s_m1a, s_m1b, s_m2a, s_m2b, s_i1, s_i2;

    logic [2:0]  r_ld_sel;
    logic        r_busy, r_rdy, r_en1, r_en2, r_clr1, r_clr2, r_v1, r_v2;
    logic [1:0]  r_m1a, r_m1b, r_m2a, r_m2b;
    logic [2:0]  r_i1, r_i2;

    gram_sched_ctrl u_d (
        .clk(clk), .rst(rst), .cf_load(cf_d), .ld_sel(d_ld_sel), .busy(d_busy),
        .output_rdy(d_rdy), .mac1a_sel(d_m1a), .mac1b_sel(d_m1b), .mac2a_sel(d_m2a),
        .mac2b_sel(d_m2b), .mac1_en(d_en1), .mac2_en(d_en2), .mac1_clr(d_clr1),
        .mac2_clr(d_clr2), .mac1_out_vld(d_v1), .mac2_out_vld(d_v2),
        .mac1_out_idx(d_i1), .mac2_out_idx(d_i2)
    );

    gram_sched_ctrl #(.ROWS(2), .COLS(2), .SEL_W(2), .IDX_W(2)) u_s (
        .clk(clk), .rst(rst), .cf_load(cf_s), .ld_sel(s_ld_sel), .busy(s_busy),
        .output_rdy(s_rdy), .mac1a_sel(s_m1a), .mac1b_sel(s_m1b), .mac2a_sel(s_m2a),
        .mac2b_sel(s_m2b), .mac1_en(s_en1), .mac2_en(s_en2), .mac1_clr(s_clr1),
        .mac2_clr(s_clr2), .mac1_out_vld(s_v1), .mac2_out_vld(s_v2),
        .mac1_out_idx(s_i1), .mac2_out_idx(s_i2)
    );

    gram_sched_ctrl #(.ROWS(1), .COLS(3), .SEL_W(2), .IDX_W(3)) u_r (
        .clk(clk), .rst(rst), .cf_load(cf_r), .ld_sel(r_ld_sel), .busy(r_busy),
        .output_rdy(r_rdy), .mac1a_sel(r_m1a), .mac1b_sel(r_m1b), .mac2a_sel(r_m2a),
        .mac2b_sel(r_m2b), .mac1_en(r_en1), .mac2_en(r_en2), .mac1_clr(r_clr1),
        .mac2_clr(r_clr2), .mac1_out_vld(r_v1), .mac2_out_vld(r_v2),
        .mac1_out_idx(r_i1), .mac2_out_idx(r_i2)
    );

    typedef struct packed {
        logic [15:0] ld_sel, busy, rdy, m1a, m1b, m2a, m2b;
        logic [15:0] en1, en2, clr1, clr2, v1, v2, i1, i2;
    } out_t;

    typedef struct packed {
        out_t d;
        out_t s;
        out_t r;
    } all_t;

    int   checks = 0;
    int   failures = 0;
    int   n_d = -1, n_s = -1, n_r = -1;
    all_t got, want;

    function automatic void pair_of(input int c_n, input int p, output int pi, output int pj);
        int c;
        c  = 0;
        pi = 0;
        pj = 0;
        for (int i = 0; i < c_n; i++)
            for (int j = i; j < c_n; j++) begin
                if (c == p) begin
                    pi = i;
                    pj = j;
                end
                c++;
            end
    endfunction

    // Expected outputs n cycles after the cf_load edge (n < 0: never loaded).
    function automatic out_t exp_out(input int r_n, input int c_n, input int n);
        out_t o;
        int   l, p_n, g_n, c, g, k, p, pi, pj;
        o = '0;
        if (n < 0) return o;
        l   = r_n * c_n;
        p_n = c_n * (c_n + 1) / 2;
        g_n = (p_n + 1) / 2;
        o.busy = (n <= l + g_n * r_n) ? 16'd1 : 16'd0;
        o.rdy  = (n >  l + g_n * r_n) ? 16'd1 : 16'd0;
        if (n < l) o.ld_sel = 16'(1 << n);
        c = n - l;
        if (c >= 0 && c < g_n * r_n) begin
            g = c / r_n;
            k = c % r_n;
            p = 2 * g;
            pair_of(c_n, p, pi, pj);
            o.m1a  = 16'(pi * r_n + k);
            o.m1b  = 16'(pj * r_n + k);
            o.en1  = 16'd1;
            o.clr1 = (k == 0) ? 16'd1 : 16'd0;
            p = 2 * g + 1;
            if (p < p_n) begin
                pair_of(c_n, p, pi, pj);
                o.m2a  = 16'(pi * r_n + k);
                o.m2b  = 16'(pj * r_n + k);
                o.en2  = 16'd1;
                o.clr2 = (k == 0) ? 16'd1 : 16'd0;
            end
        end
        if (c >= r_n && c % r_n == 0 && c / r_n <= g_n) begin
            g = c / r_n - 1;
            o.v1 = 16'd1;
            o.i1 = 16'(2 * g);
            if (2 * g + 1 < p_n) begin
                o.v2 = 16'd1;
                o.i2 = 16'(2 * g + 1);
            end
        end
        return o;
    endfunction

    function automatic all_t exp_all();
        all_t a;
        a.d = exp_out(3, 4, n_d);
        a.s = exp_out(2, 2, n_s);
        a.r = exp_out(1, 3, n_r);
        return a;
    endfunction

    function automatic all_t obs_all();
        all_t a;
        a.d.ld_sel = 16'(d_ld_sel); a.d.busy = 16'(d_busy); a.d.rdy = 16'(d_rdy);
        a.d.m1a = 16'(d_m1a); a.d.m1b = 16'(d_m1b); a.d.m2a = 16'(d_m2a); a.d.m2b = 16'(d_m2b);
        a.d.en1 = 16'(d_en1); a.d.en2 = 16'(d_en2); a.d.clr1 = 16'(d_clr1); a.d.clr2 = 16'(d_clr2);
        a.d.v1 = 16'(d_v1); a.d.v2 = 16'(d_v2); a.d.i1 = 16'(d_i1); a.d.i2 = 16'(d_i2);
        a.s.ld_sel = 16'(s_ld_sel); a.s.busy = 16'(s_busy); a.s.rdy = 16'(s_rdy);
        a.s.m1a = 16'(s_m1a); a.s.m1b = 16'(s_m1b); a.s.m2a = 16'(s_m2a); a.s.m2b = 16'(s_m2b);
        a.s.en1 = 16'(s_en1); a.s.en2 = 16'(s_en2); a.s.clr1 = 16'(s_clr1); a.s.clr2 = 16'(s_clr2);
        a.s.v1 = 16'(s_v1); a.s.v2 = 16'(s_v2); a.s.i1 = 16'(s_i1); a.s.i2 = 16'(s_i2);
        a.r.ld_sel = 16'(r_ld_sel); a.r.busy = 16'(r_busy); a.r.rdy = 16'(r_rdy);
        a.r.m1a = 16'(r_m1a); a.r.m1b = 16'(r_m1b); a.r.m2a = 16'(r_m2a); a.r.m2b = 16'(r_m2b);
        a.r.en1 = 16'(r_en1); a.r.en2 = 16'(r_en2); a.r.clr1 = 16'(r_clr1); a.r.clr2 = 16'(r_clr2);
        a.r.v1 = 16'(r_v1); a.r.v2 = 16'(r_v2); a.r.i1 = 16'(r_i1); a.r.i2 = 16'(r_i2);
        return a;
    endfunction

    // One clock edge with the given start pulses; tracks cycles since each start.
    task automatic tick(input bit ld_d, input bit ld_s, input bit ld_r);
        cf_d = ld_d;
        cf_s = ld_s;
        cf_r = ld_r;
        @(posedge clk);
        if (!rst) begin
            n_d = ld_d ? 0 : ((n_d >= 0) ? n_d + 1 : -1);
            n_s = ld_s ? 0 : ((n_s >= 0) ? n_s + 1 : -1);
            n_r = ld_r ? 0 : ((n_r >= 0) ? n_r + 1 : -1);
        end
        #1;
        cf_d = 1'b0;
        cf_s = 1'b0;
        cf_r = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        got = obs_all(); want = exp_all(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got, want);
        end
        tick(0, 0, 0);
        tick(0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            got = obs_all(); want = exp_all(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_load_reset();
        tick(1, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);
        checks++;
        if (d_ld_sel !== 12'h010) begin
            failures++;
            $display("FAIL load_ld_sel got=%h exp=010", d_ld_sel);
        end
        #2 rst = 1'b1;
        n_d = -1; n_s = -1; n_r = -1;
        #1;
        got = obs_all(); want = exp_all(); checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", got, want);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0);
            got = obs_all(); want = exp_all(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL post_reset_idle cyc=%0d got=%h exp=%h", i, got, want);
            end
        end
    endtask

    task automatic test_sequence();
        tick(1, 1, 1);
        for (int i = 0; i < 36; i++) begin
            got = obs_all(); want = exp_all(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL sequence n=%0d got=%h exp=%h", n_d, got, want);
            end
            if (n_d == 27 || n_d == 28) begin
                checks++;
                if (d_rdy !== (n_d == 28) || d_busy !== (n_d == 27)) begin
                    failures++;
                    $display("FAIL completion_edge n=%0d got rdy=%b busy=%b", n_d, d_rdy, d_busy);
                end
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_restart_mid();
        int stop;
        stop = 14 + int'($urandom_range(0, 12));
        tick(1, 0, 0);
        while (n_d < stop) begin
            got = obs_all(); want = exp_all(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL first_run n=%0d got=%h exp=%h", n_d, got, want);
            end
            tick(0, 0, 0);
        end
        tick(1, 0, 0);
        for (int i = 0; i < 33; i++) begin
            got = obs_all(); want = exp_all(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL restart_mid n=%0d got=%h exp=%h", n_d, got, want);
            end
            if (n_d == 28) begin
                checks++;
                if (d_rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL restart_completion got rdy=%b exp=1", d_rdy);
                end
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_done_restart();
        tick(1, 1, 1);
        checks++;
        if (d_rdy !== 1'b0 || d_busy !== 1'b1) begin
            failures++;
            $display("FAIL done_restart got rdy=%b busy=%b exp rdy=0 busy=1", d_rdy, d_busy);
        end
        for (int i = 0; i < 34; i++) begin
            got = obs_all(); want = exp_all(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL done_rerun n=%0d got=%h exp=%h", n_d, got, want);
            end
            tick(0, 0, 0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 39) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
            got = obs_all(); want = exp_all(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random cyc=%0d n=%0d/%0d/%0d got=%h exp=%h",
                         i, n_d, n_s, n_r, got, want);
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        cf_d = 1'b0;
        cf_s = 1'b0;
        cf_r = 1'b0;
        test_reset();
        test_load_reset();
        test_sequence();
        test_restart_mid();
        test_done_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gram_sched_ctrl.md
Name: gram_sched_ctrl

Overview:
- Parametrised load/compute scheduler for the matrix-multiplier datapath; computes the Gram product B = AᵀA of a ROWS x COLS coefficient matrix A, where b_ij = Σ_k a_ki·a_kj.
- Sequences coefficient loading with a one-hot register-file write select, then drives operand selects, enable and clear for two MAC units. Each MAC computes one upper-triangle element of B per group of ROWS cycles.
- Generalises the fixed 3x4 controller: it adds arbitrary matrix size, asynchronous reset, a busy/done handshake, result-index tagging and clean restart.

Parameters:
- ROWS, 3, rows of A (accumulation depth); >=1
- COLS, 4, columns of A; B is COLS x COLS; >=1
- SEL_W, 4, operand select width; >= clog2(ROWS*COLS)
- IDX_W, 4, result index width; >= clog2(COLS*(COLS+1)/2)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- cf_load  in  1  start pulse; sampled each edge; restarts the sequence from any state
- ld_sel  out  ROWS*COLS  one-hot coefficient write select
- busy  out  1  high from the edge sampling cf_load until results are complete
- output_rdy  out  1  level; high once all B elements are emitted, until the next cf_load or reset
- mac1a_sel, mac1b_sel, mac2a_sel, mac2b_sel  out  SEL_W each  operand selects
- mac1_en, mac2_en  out  1 each  MAC accumulate enable
- mac1_clr, mac2_clr  out  1 each  MAC loads the product instead of accumulating (qualified by en)
- mac1_out_vld, mac2_out_vld  out  1 each  MAC result is complete this cycle
- mac1_out_idx, mac2_out_idx  out  IDX_W each  linear upper-triangle index of that result

Behaviour:
- All outputs are registered. Reset and idle values: all outputs 0.
- Operand encoding: a_ki (row k, column i, zero-based) has select i*ROWS + k (column-major), matching ld_sel bit order.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE: waits for cf_load.
- Any state, cf_load=1 at edge E:
  - go to LOAD
  - clear output_rdy, all counters and any pending out_vld
  - busy=1 after E
- LOAD:
  - ld_sel = 1<<n in the n-th cycle after E, n = 0..L-1, where L = ROWS*COLS.
  - Then go to COMPUTE.
- Pair list: (i,j) with i<=j, i outer, j inner; index p = 0..P-1, P = COLS*(COLS+1)/2.
- Pair assignment:
  - group g (0..G-1, G = ceil(P/2)): MAC1 takes p = 2g, MAC2 takes p = 2g+1.
  - If p >= P, that MAC's en=0 and its selects are 0 for the group.
- COMPUTE:
  - group g occupies ROWS cycles, k = 0..ROWS-1.
  - MACx a_sel = i*ROWS + k, b_sel = j*ROWS + k; en=1; clr=1 only at k=0.
- Result strobe:
  - out_vld for group g asserts in the cycle after its k=ROWS-1 cycle, with out_idx = p.
  - For groups 0..G-2 this overlaps the next group's k=0 cycle. For the last group it is the single DRAIN cycle.
  - out_vld is never asserted for an idle MAC.
- After DRAIN:
  - go to DONE: output_rdy=1, busy=0.
  - output_rdy rises L + G*ROWS + 1 edges after E (defaults: 28).
- ROWS=1: every compute cycle has clr=1, and each group is one cycle.
- Reset mid-operation: outputs drop to 0 immediately (asynchronous) and the state is IDLE.

Test Plan:
- Reset asserted in LOAD with ld_sel=0x010 -> all outputs 0 immediately; after release, ld_sel stays 0 until cf_load.
- Defaults, cf_load pulse -> load and first group:
  - ld_sel walks 0x001..0x800 over 12 cycles.
  - First compute cycle: mac1a/b=0/0, mac2a/b=0/3, clr=1.
  - Next two cycles: selects 1/1,1/4 then 2/2,2/5, clr=0.
- Defaults, result strobes and completion:
  - out_vld pairs (idx 0,1),(2,3),(4,5),(6,7),(8,9), each 3 cycles apart.
  - output_rdy=1 and busy=0 exactly 28 edges after cf_load.
- ROWS=2, COLS=2 (P=3) -> group 1: MAC1 computes p=2 (selects 2/2, 3/3); mac2_en=0 and mac2_out_vld never asserts for idx 3.
- Defaults, cf_load re-asserted mid-COMPUTE -> output_rdy stays 0, no stale out_vld, ld_sel restarts at 0x001, and the full sequence repeats with completion 28 edges after the second pulse.
- cf_load while in DONE -> output_rdy clears the next cycle, busy=1, and the sequence reruns identically.
